secuenciador_morse: RTL
=======================

// Module: secuenciador_morse
// PURPOSE
//  Transmits one 4-bit character code (0-9, A-F) as Morse on a single key line.
//  Sequences the 4-to-16 one-hot character decoder: drives its select input,
//  samples its one-hot output and maps it to a dot/dash pattern.
//  Generates the unit timing for marks and gaps, with a valid/ready start handshake.
//  Sits between the character-entry logic and the tone/LED driver.
// PARAMETERS
//  UNIT_CYCLES  5_000_000  clk cycles per Morse time unit (50 ms at 100 MHz); >=1
// PORTS
//  clk          in   1   system clock; all logic on rising edge
//  reset        in   1   synchronous, active-high reset
//  inicio       in   1   start request; codigo is valid while high
//  codigo       in   4   character code: 0x0-0x9 digits, 0xA-0xF letters A-F
//  listo        out  1   ready; high only in IDLE
//  deco_entrada out  4   select driven to the external 4-to-16 decoder
//  deco_salida  in  16   one-hot decoder output, combinational from deco_entrada
//  tono         out  1   Morse key; 1 = mark
//  fin          out  1   1-cycle pulse: character fully sent, including the trailing gap
//  error        out  1   1-cycle pulse: decoder output not exactly one-hot
// BEHAVIOUR
//  Reset values: listo=1 (IDLE), deco_entrada=0, tono=0, fin=0, error=0.
//  Reset is honoured in any state, mid-character included; the next cycle is IDLE.
//  Handshake: transfer when inicio && listo. codigo is registered into deco_entrada
//   on that edge. inicio is ignored while listo=0; there is no queueing.
//  States: IDLE -> DECODE -> MARK -> {GAP -> MARK ...} -> CHAR_GAP -> IDLE.
//  DECODE (1 cycle): sample deco_salida.
//   - Not exactly one bit set: pulse error, go to IDLE. tono stays 0; fin is not pulsed.
//   - Otherwise load the pattern: length L (1-5) and symbols, MSB first, 1 = dash.
//  Pattern table:
//   0 -----  1 .----  2 ..---  3 ...--  4 ....-  5 .....  6 -....  7 --...
//   8 ---..  9 ----.  A .-     B -...   C -.-.   D -..    E .      F ..-.
//  MARK: tono=1 for 1 unit (dot) or 3 units (dash); 1 unit = UNIT_CYCLES cycles.
//  GAP: tono=0 for 1 unit; entered between symbols while symbols remain.
//  CHAR_GAP: tono=0 for 3 units after the last symbol.
//  Return to IDLE: fin=1 and listo=1 in the first IDLE cycle.
//   An inicio in that same cycle is accepted (back-to-back characters).
//  Latency: accept at cycle 0; DECODE at cycle 1; tono rises at cycle 2.
//  Timing counter: width $clog2(3*UNIT_CYCLES+1); reloaded on every state entry;
//   no wrap-around at any parameter value.
//  deco_entrada holds its value until the next accepted transfer.
// CONFIGURATION
//  MORSE_ABORT_EN defined:
//   - Adds input abortar (1 bit).
//   - abortar=1 in any non-IDLE state: next cycle is IDLE, tono=0, fin and error not pulsed.
//   - abortar in IDLE: no effect.
//   - reset has priority over abortar.
//  MORSE_ABORT_EN undefined: the port does not exist; a character always completes.
// TESTING (UNIT_CYCLES=4, decoder model attached, cycle 0 = accept)
//  1. codigo=0xE -> tono=1 cycles 2-5; 0 cycles 6-17; fin=1 and listo=1 at cycle 18.
//  2. codigo=0xA -> tono=1 at 2-5, 0 at 6-9, 1 at 10-21, 0 at 22-33; fin at 34.
//  3. deco_salida forced 16'h0003 -> error=1 at cycle 2, listo=1 at cycle 2;
//     tono never 1; fin never 1.
//  4. Back-to-back: 0xE, then 0x5 with inicio held high -> second accept in the fin
//     cycle (18); five dots follow with 1-unit gaps. inicio pulses while busy are ignored.
//  5. reset=1 at cycle 12 during the dash of 0x0 -> cycle 13: tono=0, listo=1,
//     deco_entrada=0, and no fin.
//  6. MORSE_ABORT_EN: codigo=0x7, abortar=1 at cycle 5 -> cycle 6: IDLE, tono=0,
//     no fin and no error; a new inicio is accepted normally.

Source files
------------

// File: rtl/secuenciador_morse.sv
// Morse sequencer: drives an external 4-to-16 decoder, maps its one-hot output to a
// dot/dash pattern and keys it out with unit timing. Optional abort input: MORSE_ABORT_EN.
module secuenciador_morse #(
  parameter int UNIT_CYCLES = 5_000_000
) (
  input  logic        clk,
  input  logic        reset,
`ifdef MORSE_ABORT_EN
  input  logic        abortar,
`endif
  input  logic        inicio,
  input  logic [3:0]  codigo,
  output logic        listo,
  output logic [3:0]  deco_entrada,
  input  logic [15:0] deco_salida,
  output logic        tono,
  output logic        fin,
  output logic        error
);

  localparam int CW = $clog2(3 * UNIT_CYCLES + 1);
  localparam logic [CW-1:0] T_UNO  = CW'(UNIT_CYCLES - 1);
  localparam logic [CW-1:0] T_TRES = CW'(3 * UNIT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, DECODE, MARK, GAP, CHAR_GAP} estado_t;

  estado_t       estado;
  logic [CW-1:0] cnt;
  logic [4:0]    simbolos;
  logic [2:0]    restantes;
  logic [3:0]    indice;
  logic          es_onehot;
  logic [7:0]    patron_act;

  // {length, symbols left-aligned MSB first}; 1 = dash
  function automatic logic [7:0] patron(input logic [3:0] c);
    case (c)
      4'h0:    patron = {3'd5, 5'b11111};
      4'h1:    patron = {3'd5, 5'b01111};
      4'h2:    patron = {3'd5, 5'b00111};
      4'h3:    patron = {3'd5, 5'b00011};
      4'h4:    patron = {3'd5, 5'b00001};
      4'h5:    patron = {3'd5, 5'b00000};
      4'h6:    patron = {3'd5, 5'b10000};
      4'h7:    patron = {3'd5, 5'b11000};
      4'h8:    patron = {3'd5, 5'b11100};
      4'h9:    patron = {3'd5, 5'b11110};
      4'hA:    patron = {3'd2, 5'b01000};
      4'hB:    patron = {3'd4, 5'b10000};
      4'hC:    patron = {3'd4, 5'b10100};
      4'hD:    patron = {3'd3, 5'b10000};
      4'hE:    patron = {3'd1, 5'b00000};
      default: patron = {3'd4, 5'b00100};
    endcase
  endfunction

  // The symbol comes from the decoder's one-hot output, not from codigo
  always_comb begin
    indice = 4'd0;
    for (int i = 0; i < 16; i++)
      if (deco_salida[i]) indice = 4'(i);
    es_onehot  = (deco_salida != 16'd0) &&
                 ((deco_salida & (deco_salida - 16'd1)) == 16'd0);
    patron_act = patron(indice);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado       <= IDLE;
      listo        <= 1'b1;
      deco_entrada <= 4'd0;
      tono         <= 1'b0;
      fin          <= 1'b0;
      error        <= 1'b0;
    end else begin
      fin   <= 1'b0;
      error <= 1'b0;
`ifdef MORSE_ABORT_EN
      if (abortar && estado != IDLE) begin
        estado <= IDLE;
        listo  <= 1'b1;
        tono   <= 1'b0;
      end else
`endif
      begin
        case (estado)
          IDLE: begin
            if (inicio) begin
              deco_entrada <= codigo;
              listo        <= 1'b0;
              estado       <= DECODE;
            end
          end
          DECODE: begin
            if (!es_onehot) begin
              error  <= 1'b1;
              listo  <= 1'b1;
              estado <= IDLE;
            end else begin
              restantes <= patron_act[7:5];
              simbolos  <= patron_act[4:0];
              cnt       <= patron_act[4] ? T_TRES : T_UNO;
              tono      <= 1'b1;
              estado    <= MARK;
            end
          end
          MARK: begin
            if (cnt == '0) begin
              tono      <= 1'b0;
              simbolos  <= {simbolos[3:0], 1'b0};
              restantes <= restantes - 3'd1;
              if (restantes == 3'd1) begin
                cnt    <= T_TRES;
                estado <= CHAR_GAP;
              end else begin
                cnt    <= T_UNO;
                estado <= GAP;
              end
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          GAP: begin
            if (cnt == '0) begin
              cnt    <= simbolos[4] ? T_TRES : T_UNO;
              tono   <= 1'b1;
              estado <= MARK;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          CHAR_GAP: begin
            if (cnt == '0) begin
              fin    <= 1'b1;
              listo  <= 1'b1;
              estado <= IDLE;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          default: begin
            listo  <= 1'b1;
            tono   <= 1'b0;
            estado <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
